// File: rtl/csr_pkg.sv
// Shared definitions for the timer/interrupt CSR slice: CSR addresses,
// ESTAT.IS bit layout and the ECFG.LIE writable mask.
package csr_pkg;

    localparam int IS_W = 13;

    localparam logic [13:0] CSR_ECFG  = 14'h0004;
    localparam logic [13:0] CSR_ESTAT = 14'h0005;
    localparam logic [13:0] CSR_TID   = 14'h0040;
    localparam logic [13:0] CSR_TCFG  = 14'h0041;
    localparam logic [13:0] CSR_TVAL  = 14'h0042;
    localparam logic [13:0] CSR_TICLR = 14'h0044;

    localparam int IS_SWI_LO = 0;
    localparam int IS_SWI_HI = 1;
    localparam int IS_HWI_LO = 2;
    localparam int IS_HWI_HI = 9;
    localparam int IS_TI     = 11;
    localparam int IS_IPI    = 12;

    // Bit 10 and unused hardware-interrupt slots are never enabled.
    function automatic logic [IS_W-1:0] lie_wmask(input int hw_int_n);
        logic [IS_W-1:0] m;
        m = '0;
        for (int i = 0; i < IS_W; i++) begin
            if ((i <= hw_int_n + 1) || (i == IS_TI) || (i == IS_IPI)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-stage level synchroniser for asynchronous interrupt inputs;
// STAGES = 0 passes the input straight through.
module int_sync #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [W-1:0] stage_r [STAGES];

            // Shift the sampled level through the synchroniser chain.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_r[i] <= '0;
                    end
                end else begin
                    stage_r[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign q = stage_r[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/csr_timer_int.sv
// Timer and interrupt CSR unit: TID/TCFG/TVAL/TICLR/ECFG and ESTAT.IS,
// countdown timer, interrupt sampling and registered interrupt request.
module csr_timer_int
    import csr_pkg::*;
#(
    parameter int          TIMER_W     = 32,
    parameter int          HW_INT_N    = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TID_RESET   = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [13:0]         csr_raddr,
    output logic [31:0]         csr_rdata,
    output logic                csr_hit,
    input  logic                csr_wr_en,
    input  logic [13:0]         csr_waddr,
    input  logic [31:0]         csr_wdata,
    input  logic                crmd_ie,
    input  logic [HW_INT_N-1:0] interrupt,
    input  logic                ipi,
    output logic [12:0]         estat_is,
    output logic                has_int,
    output logic [3:0]          int_idx
);

    localparam logic [IS_W-1:0] LIE_MASK = lie_wmask(HW_INT_N);

    logic [31:0]         tid_r;
    logic [TIMER_W-1:0]  tcfg_r;
    logic [TIMER_W-1:0]  tval_r;
    logic                timer_en_r;
    logic                ti_r;
    logic [1:0]          swi_r;
    logic [IS_W-1:0]     lie_r;
    logic                has_int_r;
    logic [3:0]          int_idx_r;

    logic [HW_INT_N:0]   sync_in_s;
    logic [HW_INT_N:0]   sync_out_s;
    logic [IS_W-1:0]     is_s;
    logic [IS_W-1:0]     pend_s;
    logic [3:0]          idx_s;
    logic                wr_tid_s;
    logic                wr_tcfg_s;
    logic                wr_ticlr_s;
    logic                wr_ecfg_s;
    logic                wr_estat_s;
    logic                ti_set_s;
    logic [TIMER_W-1:0]  wr_reload_s;
    logic [TIMER_W-1:0]  cfg_reload_s;

    assign sync_in_s = {ipi, interrupt};

    int_sync #(
        .STAGES (SYNC_STAGES),
        .W      (HW_INT_N + 1)
    ) u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sync_in_s),
        .q     (sync_out_s)
    );

    assign wr_tid_s   = csr_wr_en && (csr_waddr == CSR_TID);
    assign wr_tcfg_s  = csr_wr_en && (csr_waddr == CSR_TCFG);
    assign wr_ticlr_s = csr_wr_en && (csr_waddr == CSR_TICLR);
    assign wr_ecfg_s  = csr_wr_en && (csr_waddr == CSR_ECFG);
    assign wr_estat_s = csr_wr_en && (csr_waddr == CSR_ESTAT);

    assign wr_reload_s  = {csr_wdata[TIMER_W-1:2], 2'b00};
    assign cfg_reload_s = {tcfg_r[TIMER_W-1:2], 2'b00};
    assign ti_set_s     = timer_en_r && (tval_r == '0);

    // Assemble the IS field: latched SWI/TI plus live synchronised levels.
    always_comb begin
        is_s = '0;
        is_s[IS_SWI_HI:IS_SWI_LO] = swi_r;
        for (int i = 0; i < HW_INT_N; i++) begin
            is_s[IS_HWI_LO + i] = sync_out_s[i];
        end
        is_s[IS_TI]  = ti_r;
        is_s[IS_IPI] = sync_out_s[HW_INT_N];
    end

    assign pend_s = is_s & lie_r;

    // Highest-numbered pending enabled bit wins.
    always_comb begin
        idx_s = 4'd0;
        for (int i = 0; i < IS_W; i++) begin
            if (pend_s[i]) begin
                idx_s = 4'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Timer configuration and countdown; a TCFG write overrides counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcfg_r     <= '0;
            tval_r     <= '0;
            timer_en_r <= 1'b0;
        end else if (wr_tcfg_s) begin
            tcfg_r     <= csr_wdata[TIMER_W-1:0];
            tval_r     <= wr_reload_s;
            timer_en_r <= csr_wdata[0];
        end else if (timer_en_r) begin
            if (tval_r != '0) begin
                tval_r <= tval_r - TIMER_W'(1);
            end else if (tcfg_r[1]) begin
                tval_r <= cfg_reload_s;
            end else begin
                timer_en_r <= 1'b0;
            end
        end
    end

    // Timer interrupt flag; a new expiry beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ti_r <= 1'b0;
        end else if (ti_set_s) begin
            ti_r <= 1'b1;
        end else if (wr_ticlr_s && csr_wdata[0]) begin
            ti_r <= 1'b0;
        end
    end

    // Software-writable registers: TID, LIE and the SWI bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tid_r <= TID_RESET;
            lie_r <= '0;
            swi_r <= 2'b00;
        end else begin
            if (wr_tid_s) begin
                tid_r <= csr_wdata;
            end
            if (wr_ecfg_s) begin
                lie_r <= csr_wdata[IS_W-1:0] & LIE_MASK;
            end
            if (wr_estat_s) begin
                swi_r <= csr_wdata[IS_SWI_HI:IS_SWI_LO];
            end
        end
    end

    // Registered interrupt request towards the exception logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            has_int_r <= 1'b0;
            int_idx_r <= 4'd0;
        end else begin
            has_int_r <= crmd_ie && (pend_s != '0);
            int_idx_r <= idx_s;
        end
    end

    // Combinational read port.
    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = 32'h0;
        case (csr_raddr)
            CSR_TID:   csr_rdata = tid_r;
            CSR_TCFG:  csr_rdata = 32'(tcfg_r);
            CSR_TVAL:  csr_rdata = 32'(tval_r);
            CSR_TICLR: csr_rdata = 32'h0;
            CSR_ECFG:  csr_rdata = 32'(lie_r);
            CSR_ESTAT: csr_rdata = 32'(is_s);
            default: begin
                csr_hit   = 1'b0;
                csr_rdata = 32'h0;
            end
        endcase
    end

    assign estat_is = is_s;
    assign has_int  = has_int_r;
    assign int_idx  = int_idx_r;

endmodule

// File: tb/tb_csr_timer_int.sv
// Self-checking bench for csr_timer_int: table-driven CSR vectors plus
// directed sequences for the timer, interrupt paths, priority and async reset.
module tb_csr_timer_int;

    logic        clk;
    logic        reset;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        csr_wr_en;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        crmd_ie;
    logic [7:0]  interrupt;
    logic        ipi;
    logic [12:0] estat_is;
    logic        has_int;
    logic [3:0]  int_idx;

    int checks;
    int failures;

    csr_timer_int #(
        .TIMER_W     (32),
        .HW_INT_N    (8),
        .SYNC_STAGES (2),
        .TID_RESET   (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .csr_raddr (csr_raddr),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit),
        .csr_wr_en (csr_wr_en),
        .csr_waddr (csr_waddr),
        .csr_wdata (csr_wdata),
        .crmd_ie   (crmd_ie),
        .interrupt (interrupt),
        .ipi       (ipi),
        .estat_is  (estat_is),
        .has_int   (has_int),
        .int_idx   (int_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic [13:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_wr_en = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
        step();
        csr_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d, output logic h);
        csr_raddr = a;
        #1;
        d = csr_rdata;
        h = csr_hit;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    vec_t        vecs [10];
    logic [31:0] d;
    logic        h;
    int          cnt;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        csr_raddr = 14'h0;
        csr_wr_en = 1'b0;
        csr_waddr = 14'h0;
        csr_wdata = 32'h0;
        crmd_ie   = 1'b0;
        interrupt = 8'h00;
        ipi       = 1'b0;

        vecs[0] = '{"tid_rw",      14'h040, 32'hDEADBEEF, 14'h040, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{"ecfg_mask",   14'h004, 32'hFFFFFFFF, 14'h004, 32'h00001BFF, 1'b1};
        vecs[2] = '{"ticlr_rd0",   14'h044, 32'h00000001, 14'h044, 32'h00000000, 1'b1};
        vecs[3] = '{"tval_ro",     14'h042, 32'h00001234, 14'h042, 32'h00000000, 1'b1};
        vecs[4] = '{"estat_swi",   14'h005, 32'h0000FFFF, 14'h005, 32'h00000003, 1'b1};
        vecs[5] = '{"ecfg_clr",    14'h004, 32'h00000000, 14'h004, 32'h00000000, 1'b1};
        vecs[6] = '{"estat_clr",   14'h005, 32'h00000000, 14'h005, 32'h00000000, 1'b1};
        vecs[7] = '{"miss_43",     14'h043, 32'h00000005, 14'h043, 32'h00000000, 1'b0};
        vecs[8] = '{"tcfg_off_tv", 14'h041, 32'hFFFFFFF0, 14'h042, 32'hFFFFFFF0, 1'b1};
        vecs[9] = '{"tcfg_zero",   14'h041, 32'h00000000, 14'h041, 32'h00000000, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        step();
        rd(14'h042, d, h);  chk("rst_tval", d, 32'h0);
        rd(14'h041, d, h);  chk("rst_tcfg", d, 32'h0);
        chk("rst_has_int", {31'h0, has_int}, 32'h0);
        step();
        rd(14'h040, d, h);  chk("rst_tid", d, 32'h0);  chk("rst_tid_hit", {31'h0, h}, 32'h1);
        rd(14'h043, d, h);  chk("rst_43_rdata", d, 32'h0);  chk("rst_43_hit", {31'h0, h}, 32'h0);
        step();

        // Table-driven CSR write/read vectors
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, d, h);
            chk({vecs[i].name, "_data"}, d, vecs[i].exp_rdata);
            chk({vecs[i].name, "_hit"}, {31'h0, h}, {31'h0, vecs[i].exp_hit});
        end

        // One-shot timer, Init=4
        crmd_ie = 1'b1;
        wr(14'h004, 32'h00000800);
        wr(14'h041, 32'h00000005);
        for (int k = 0; k < 5; k++) begin
            rd(14'h042, d, h);
            chk("os_tval", d, 32'(4 - k));
            chk("os_ti_low", {31'h0, estat_is[11]}, 32'h0);
            step();
        end
        chk("os_ti_set", {31'h0, estat_is[11]}, 32'h1);
        chk("os_has_int_lag", {31'h0, has_int}, 32'h0);
        step();
        chk("os_has_int", {31'h0, has_int}, 32'h1);
        chk("os_idx", {28'h0, int_idx}, 32'd11);
        repeat (3) step();
        rd(14'h042, d, h);  chk("os_tval_hold", d, 32'h0);
        wr(14'h044, 32'h00000001);
        chk("os_ticlr", {31'h0, estat_is[11]}, 32'h0);
        step();
        chk("os_has_int_clr", {31'h0, has_int}, 32'h0);

        // Periodic timer, reload 8 -> TI every 9 cycles
        wr(14'h041, 32'h0000000B);
        cnt = 0;
        while (!estat_is[11] && cnt < 20) begin step(); cnt++; end
        chk("per_first_ti", 32'(cnt), 32'd9);
        rd(14'h042, d, h);  chk("per_reload", d, 32'h8);
        wr(14'h044, 32'h00000001);
        chk("per_clr", {31'h0, estat_is[11]}, 32'h0);
        cnt = 0;
        while (!estat_is[11] && cnt < 20) begin step(); cnt++; end
        chk("per_second_ti", 32'(cnt), 32'd8);
        wr(14'h044, 32'h00000001);
        chk("per_clr2", {31'h0, estat_is[11]}, 32'h0);
        repeat (7) step();
        rd(14'h042, d, h);  chk("per_tval0", d, 32'h0);
        wr(14'h044, 32'h00000001);
        chk("per_set_wins", {31'h0, estat_is[11]}, 32'h1);
        rd(14'h042, d, h);  chk("per_reload2", d, 32'h8);
        wr(14'h041, 32'h00000000);
        wr(14'h044, 32'h00000001);
        chk("per_stop_clr", {31'h0, estat_is[11]}, 32'h0);

        // Hardware interrupt line 3 -> IS[5]
        wr(14'h004, 32'h00000020);
        interrupt = 8'h08;
        step();  chk("hw_is_s1", {31'h0, estat_is[5]}, 32'h0);
        step();  chk("hw_is_s2", {31'h0, estat_is[5]}, 32'h1);
        chk("hw_has_int_lag", {31'h0, has_int}, 32'h0);
        step();  chk("hw_has_int", {31'h0, has_int}, 32'h1);
        chk("hw_idx", {28'h0, int_idx}, 32'd5);
        interrupt = 8'h00;
        step();  chk("hw_drop_s1", {31'h0, estat_is[5]}, 32'h1);
        step();  chk("hw_drop_s2", {31'h0, estat_is[5]}, 32'h0);
        wr(14'h005, 32'h0000FFFF);
        chk("hw_estat_wr", {19'h0, estat_is}, 32'h3);

        // Priority: IS[0], IS[11], IS[12]
        wr(14'h004, 32'h00001801);
        ipi = 1'b1;
        wr(14'h041, 32'h00000001);
        step();
        step();
        chk("pri_has_int", {31'h0, has_int}, 32'h1);
        chk("pri_idx12", {28'h0, int_idx}, 32'd12);
        wr(14'h004, 32'h00000801);
        step();  chk("pri_idx11", {28'h0, int_idx}, 32'd11);
        wr(14'h004, 32'h00000001);
        step();  chk("pri_idx0", {28'h0, int_idx}, 32'd0);
        chk("pri_idx0_has", {31'h0, has_int}, 32'h1);
        wr(14'h004, 32'h00000000);
        step();  chk("pri_none_has", {31'h0, has_int}, 32'h0);
        chk("pri_none_idx", {28'h0, int_idx}, 32'd0);
        wr(14'h004, 32'h00000800);
        step();  chk("ie_on", {31'h0, has_int}, 32'h1);
        crmd_ie = 1'b0;
        step();  chk("ie_drop", {31'h0, has_int}, 32'h0);
        crmd_ie = 1'b1;
        step();  chk("ie_back", {31'h0, has_int}, 32'h1);

        // Async reset mid-count
        ipi = 1'b0;
        wr(14'h005, 32'h00000000);
        wr(14'h041, 32'h00000101);
        rd(14'h042, d, h);  chk("ar_tval_pre", d, 32'h100);
        chk("ar_has_int_pre", {31'h0, has_int}, 32'h1);
        #2 reset = 1'b0;
        #1;
        rd(14'h042, d, h);  chk("ar_tval", d, 32'h0);
        chk("ar_has_int", {31'h0, has_int}, 32'h0);
        chk("ar_is", {19'h0, estat_is}, 32'h0);
        #2 reset = 1'b1;
        repeat (5) step();
        rd(14'h042, d, h);  chk("ar_stopped_tval", d, 32'h0);
        rd(14'h041, d, h);  chk("ar_stopped_tcfg", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
